// File: rtl/pipe_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Arbiter FSM states, requester ids and the read-latency bound.
package pipe_pkg;

    localparam int MEM_LAT_MAX = 4;
    localparam int LAT_W       = $clog2(MEM_LAT_MAX);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_e;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin grant logic: bit 0 = core, bit 1 = debug.
// The last winner loses the next conflict; history moves only when upd_en is set.
module rr_arb2
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd_en,
    output logic [1:0] gnt
);

    req_id_e last_gnt_r;

    // One-hot grant selection from the request vector and history
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_gnt_r == REQ_DBG) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Winner history; debug after reset so the core wins the first conflict
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt_r <= REQ_DBG;
        end else if (upd_en && (gnt != 2'b00)) begin
            last_gnt_r <= gnt[1] ? REQ_DBG : REQ_CORE;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data memory between the core MW stage and the debug/loader port.
// Writes complete in the grant cycle; reads hold the address for MEM_LAT cycles.
module dmem_arbiter
    import pipe_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    output logic              core_gnt_o,
    output logic              core_rvalid_o,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              core_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [DATA_W-1:0] dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [DATA_W-1:0] dbg_rdata_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    arb_state_e        state_r, state_nxt_s;
    logic [LAT_W-1:0]  lat_cnt_r, lat_cnt_nxt_s;
    req_id_e           owner_r, owner_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [DATA_W-1:0] wdata_r, wdata_nxt_s;
    logic              idle_s;
    logic              rvalid_s;
    logic [1:0]        arb_req_s;
    logic [1:0]        arb_gnt_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;
    req_id_e           sel_id_s;

    // Arbitration is only open in IDLE and never while reset is applied
    always_comb begin
        if (rst_n_i && (state_r == ARB_IDLE)) begin
            idle_s    = 1'b1;
            arb_req_s = {dbg_req_i, core_req_i};
        end else begin
            idle_s    = 1'b0;
            arb_req_s = 2'b00;
        end
    end

    rr_arb2 u_rr_arb2 (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .req    (arb_req_s),
        .upd_en (idle_s),
        .gnt    (arb_gnt_s)
    );

    // Mux the winning requester's command
    always_comb begin
        if (arb_gnt_s[1]) begin
            sel_we_s    = dbg_we_i;
            sel_addr_s  = dbg_addr_i;
            sel_wdata_s = dbg_wdata_i;
            sel_id_s    = REQ_DBG;
        end else begin
            sel_we_s    = core_we_i;
            sel_addr_s  = core_addr_i;
            sel_wdata_s = core_wdata_i;
            sel_id_s    = REQ_CORE;
        end
    end

    // Next-state, latency counting and memory-side drive
    always_comb begin
        state_nxt_s   = state_r;
        lat_cnt_nxt_s = lat_cnt_r;
        owner_nxt_s   = owner_r;
        addr_nxt_s    = addr_r;
        wdata_nxt_s   = wdata_r;
        rvalid_s      = 1'b0;
        mem_we_o      = 1'b0;
        mem_addr_o    = addr_r;
        mem_wdata_o   = wdata_r;
        case (state_r)
            ARB_IDLE: begin
                if (arb_gnt_s != 2'b00) begin
                    mem_we_o    = sel_we_s;
                    mem_addr_o  = sel_addr_s;
                    mem_wdata_o = sel_wdata_s;
                    addr_nxt_s  = sel_addr_s;
                    wdata_nxt_s = sel_wdata_s;
                    owner_nxt_s = sel_id_s;
                    if (!sel_we_s) begin
                        state_nxt_s   = ARB_WAIT;
                        lat_cnt_nxt_s = LAT_W'(MEM_LAT - 1);
                    end else begin
                        state_nxt_s = ARB_IDLE;
                    end
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_WAIT: begin
                if (lat_cnt_r == {LAT_W{1'b0}}) begin
                    rvalid_s    = rst_n_i;
                    state_nxt_s = ARB_IDLE;
                end else begin
                    lat_cnt_nxt_s = lat_cnt_r - {{(LAT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ARB_IDLE;
            end
        endcase
    end

    // Route the returning read to its owner; rdata is zero outside the strobe
    always_comb begin
        core_gnt_o    = arb_gnt_s[0];
        dbg_gnt_o     = arb_gnt_s[1];
        core_rvalid_o = 1'b0;
        core_rdata_o  = {DATA_W{1'b0}};
        dbg_rvalid_o  = 1'b0;
        dbg_rdata_o   = {DATA_W{1'b0}};
        if (rvalid_s && (owner_r == REQ_DBG)) begin
            dbg_rvalid_o = 1'b1;
            dbg_rdata_o  = mem_rdata_i;
        end else if (rvalid_s) begin
            core_rvalid_o = 1'b1;
            core_rdata_o  = mem_rdata_i;
        end else begin
            core_rvalid_o = 1'b0;
        end
    end

    assign core_stall_o = core_req_i & ~((core_gnt_o & core_we_i) | core_rvalid_o);

    // State and held-command registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r   <= ARB_IDLE;
            lat_cnt_r <= {LAT_W{1'b0}};
            owner_r   <= REQ_CORE;
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            lat_cnt_r <= lat_cnt_nxt_s;
            owner_r   <= owner_nxt_s;
            addr_r    <= addr_nxt_s;
            wdata_r   <= wdata_nxt_s;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory between the pipeline's memory/writeback stage (core port) and a debug/loader port (dbg port). It grants one access at a time with round-robin priority, keeps the memory address stable for the full read latency, returns read data with a one-cycle valid strobe, and drives a stall to the pipeline until the core access completes. It sits between the MW-stage signals and the data memory instance.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, data-memory read latency in cycles; legal range 1..4.

- clk_i  in  1  clock.
- rst_n_i  in  1  reset; one clock, synchronous, active-low.
- core_req_i  in  1  core access request; level, held until completion.
- core_we_i  in  1  core write (1) / read (0).
- core_addr_i  in  ADDR_W  core address.
- core_wdata_i  in  DATA_W  core write data.
- core_gnt_o  out  1  core access accepted this cycle.
- core_rvalid_o  out  1  core read data valid, one-cycle pulse.
- core_rdata_o  out  DATA_W  core read data; 0 when core_rvalid_o=0.
- core_stall_o  out  1  pipeline stall; core request not yet completed.
- dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i  in  1/1/ADDR_W/DATA_W  debug port, same semantics as core.
- dbg_gnt_o, dbg_rvalid_o  out  1  debug grant, debug read-valid.
- dbg_rdata_o  out  DATA_W  debug read data; 0 when dbg_rvalid_o=0.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  ADDR_W  memory address.
- mem_wdata_o  out  DATA_W  memory write data.
- mem_rdata_i  in  DATA_W  memory read data, valid MEM_LAT cycles after the address is presented.

## Operation
- States: ARB_IDLE, ARB_WAIT. Reset state: ARB_IDLE. last_gnt reset value: DBG, so the core wins the first conflict.
- ARB_IDLE, no request: all grants 0, mem_we_o=0, mem_addr_o holds its last value (0 after reset).
- ARB_IDLE, one request: grant that requester in the same cycle. Drive mem_addr_o, mem_wdata_o and mem_we_o from it. Register the address and requester id. Update last_gnt.
- ARB_IDLE, both requesting: grant the requester that is not last_gnt.
- Granted write: completes in the grant cycle and stays in ARB_IDLE. The next grant is allowed in the following cycle.
- Granted read: go to ARB_WAIT and load lat_cnt=MEM_LAT-1. mem_we_o=0 and mem_addr_o is held at the registered address.
- ARB_WAIT: no grants. Decrement lat_cnt each cycle. When lat_cnt==0, pulse rvalid to the owner, pass mem_rdata_i to its rdata, and return to ARB_IDLE.
- Requests are not re-evaluated until ARB_IDLE. At most one read is outstanding.
- core_stall_o = core_req_i & ~core_done.
  - core_done = core_gnt_o & core_we_i for writes.
  - core_done = core_rvalid_o for reads.
  - core_stall_o is combinational.
- Requester rule: a requester deasserts req in the cycle after its gnt (write) or rvalid (read). Changing addr/we/wdata while req=1 and not granted is illegal.
- Address/data are passed through unmodified. Byte/half alignment is handled upstream.

## Timing
- Write latency: 0 cycles. gnt and mem_we_o are in the same cycle as req when the arbiter is in ARB_IDLE.
- Read latency: rvalid arrives MEM_LAT cycles after gnt. MEM_LAT=1 gives rvalid in the cycle after gnt.
- Back-to-back throughput:
  - writes: 1 per cycle;
  - reads: 1 per MEM_LAT+1 cycles.
- Reset values: all gnt/rvalid/stall-independent outputs 0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, rdata outputs 0.
- Reset mid-read: the transaction is abandoned, no rvalid is issued, and the arbiter returns to ARB_IDLE.
- A request that arrives during ARB_WAIT is served in the first ARB_IDLE cycle.
- Simultaneous requests arriving in the rvalid cycle are resolved by round-robin in the next cycle.

## Structure
- Shared package pipe_pkg:
  - typedef enum arb_state_e {ARB_IDLE, ARB_WAIT};
  - typedef enum logic {REQ_CORE, REQ_DBG} req_id_e;
  - MEM_LAT_MAX=4.
- Sub-module rr_arb2: 2-way round-robin grant logic with a last_gnt register, update-enable input and one-hot grant output. The FSM, latency counter and muxing stay in dmem_arbiter.
- Latency counter width: $clog2(MEM_LAT_MAX).

## Test plan
- Reset, then core write addr=0x10 data=0xDEADBEEF → core_gnt_o=1 and mem_we_o=1 in the same cycle; core_stall_o=0 that cycle.
- Core read 0x10 with MEM_LAT=2 → gnt at cycle t; core_rvalid_o at t+2 with rdata=0xDEADBEEF; core_stall_o=1 at t and t+1; dbg_gnt_o=0 throughout.
- Both ports request writes continuously → grants alternate core, dbg, core, dbg, starting with core after reset.
- Dbg read pending with MEM_LAT=3 while core_req_i rises at t+1 → core_gnt_o is first asserted at t+4; core_stall_o=1 from t+1 to t+3.
- Reset asserted at t+1 of a MEM_LAT=3 read → no rvalid; all outputs 0 on the next cycle; next request is granted immediately after reset release.
- Sweep MEM_LAT=1..4 with random core/dbg traffic against a scoreboard memory → every read returns the last written value; no grant during ARB_WAIT.
